// File: rtl/uart_alu_master.sv
// Sends operand A, operand B and an opcode byte to a UART TX FIFO, then waits
// for one result byte on the RX FIFO, with a bounded wait that aborts on timeout.
module uart_alu_master #(
  parameter int BUS_SIZE = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic [BUS_SIZE-1:0] i_opA,
  input  logic [BUS_SIZE-1:0] i_opB,
  input  logic [BUS_SIZE-3:0] i_opCode,
  input  logic                tx_full_signal,
  output logic                wr_signal,
  output logic [BUS_SIZE-1:0] o_wdata,
  input  logic                rx_empty_signal,
  input  logic [BUS_SIZE-1:0] i_rdata,
  output logic                rd_signal,
  output logic [BUS_SIZE-1:0] o_result,
  output logic                o_busy,
  output logic                o_done_tick,
  output logic                o_timeout
);

  localparam int                CntW    = $clog2(TIMEOUT);
  localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSendA   = 3'd1;
  localparam logic [2:0] StSendB   = 3'd2;
  localparam logic [2:0] StSendOp  = 3'd3;
  localparam logic [2:0] StWaitRes = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]          state_q, state_d;
  logic [BUS_SIZE-1:0] op_a_q, op_a_d;
  logic [BUS_SIZE-1:0] op_b_q, op_b_d;
  logic [BUS_SIZE-3:0] op_code_q, op_code_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [BUS_SIZE-1:0] result_q, result_d;
  logic                timeout_q, timeout_d;
  logic                done_q, done_d;

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    done_d    = 1'b0;
    wr_signal = 1'b0;
    rd_signal = 1'b0;
    o_wdata   = '0;

    case (state_q)
      StIdle: begin
        if (i_start) begin
          op_a_d    = i_opA;
          op_b_d    = i_opB;
          op_code_d = i_opCode;
          timeout_d = 1'b0;
          state_d   = StSendA;
        end
      end
      StSendA: begin
        o_wdata   = op_a_q;
        wr_signal = ~tx_full_signal;
        if (wr_signal) state_d = StSendB;
      end
      StSendB: begin
        o_wdata   = op_b_q;
        wr_signal = ~tx_full_signal;
        if (wr_signal) state_d = StSendOp;
      end
      StSendOp: begin
        o_wdata   = {2'b00, op_code_q};
        wr_signal = ~tx_full_signal;
        if (wr_signal) begin
          cnt_d   = '0;
          state_d = StWaitRes;
        end
      end
      StWaitRes: begin
        rd_signal = ~rx_empty_signal;
        // Data on the last allowed cycle still wins over the timeout.
        if (rd_signal) begin
          result_d = i_rdata;
          done_d   = 1'b1;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
    end
  end

  // The done pulse is registered: it lands in DONE on success, or in the first
  // IDLE cycle after a timeout, together with o_timeout.
  assign o_done_tick = done_q;
  assign o_result    = result_q;
  assign o_timeout   = timeout_q;
  assign o_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_alu_master.sv
// Directed bench for uart_alu_master: a transaction-level model checked every
// cycle, plus literal expectations for the worked scenarios.
module tb_uart_alu_master;

  localparam int Bw = 8;
  localparam int To = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic [Bw-1:0] i_opA = '0, i_opB = '0;
  logic [Bw-3:0] i_opCode = '0;
  logic          tx_full_signal = 1'b0;
  logic          wr_signal;
  logic [Bw-1:0] o_wdata;
  logic          rx_empty_signal = 1'b1;
  logic [Bw-1:0] i_rdata = '0;
  logic          rd_signal;
  logic [Bw-1:0] o_result;
  logic          o_busy, o_done_tick, o_timeout;

  int n_pass = 0;
  int n_total = 0;

  uart_alu_master #(.BUS_SIZE(Bw), .TIMEOUT(To)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_start        (i_start),
    .i_opA          (i_opA),
    .i_opB          (i_opB),
    .i_opCode       (i_opCode),
    .tx_full_signal (tx_full_signal),
    .wr_signal      (wr_signal),
    .o_wdata        (o_wdata),
    .rx_empty_signal(rx_empty_signal),
    .i_rdata        (i_rdata),
    .rd_signal      (rd_signal),
    .o_result       (o_result),
    .o_busy         (o_busy),
    .o_done_tick    (o_done_tick),
    .o_timeout      (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: phase 0 idle, 1 sending bytes, 2 awaiting result, 3 done.
  int            m_phase = 0;
  int            m_wait = 0;
  logic [Bw-1:0] m_bytes[$];
  logic [Bw-1:0] m_result = '0;
  logic          m_timeout = 1'b0;
  logic          m_done = 1'b0;

  always @(negedge clk) begin
    logic exp_wr, exp_rd, nd;
    if (reset) begin
      m_phase = 0; m_result = '0; m_timeout = 1'b0; m_done = 1'b0;
      m_bytes.delete();
    end
    exp_wr = (m_phase == 1) && !tx_full_signal;
    exp_rd = (m_phase == 2) && !rx_empty_signal;
    chk("model_busy", o_busy, m_phase != 0);
    chk("model_wr", wr_signal, exp_wr);
    chk("model_rd", rd_signal, exp_rd);
    chk("model_done", o_done_tick, m_done);
    chk("model_result", o_result, m_result);
    chk("model_timeout", o_timeout, m_timeout);
    if (exp_wr && m_bytes.size() > 0) chk("model_wdata", o_wdata, m_bytes[0]);
    if (!reset) begin
      nd = 1'b0;
      case (m_phase)
        0: if (i_start) begin
          m_bytes.delete();
          m_bytes.push_back(i_opA);
          m_bytes.push_back(i_opB);
          m_bytes.push_back({2'b00, i_opCode});
          m_timeout = 1'b0;
          m_phase = 1;
        end
        1: if (!tx_full_signal) begin
          void'(m_bytes.pop_front());
          if (m_bytes.size() == 0) begin m_phase = 2; m_wait = 0; end
        end
        2: if (!rx_empty_signal) begin
          m_result = i_rdata; m_phase = 3; nd = 1'b1;
        end else if (m_wait == To - 1) begin
          m_phase = 0; m_timeout = 1'b1; nd = 1'b1;
        end else begin
          m_wait++;
        end
        default: m_phase = 0;
      endcase
      m_done = nd;
    end
  end

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    i_opA = a; i_opB = b; i_opCode = op; i_start = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_wr", wr_signal, 0);
    chk("rst_wdata", o_wdata, 0);
    chk("rst_result", o_result, 0);
    chk("rst_timeout", o_timeout, 0);
    adv(); adv(); reset = 1'b0;
    adv();

    // Basic transaction: 05,03,20 -> 08
    start(8'h05, 8'h03, 6'h20); rx_empty_signal = 1'b0; i_rdata = 8'h08;
    adv(); i_start = 1'b0; smp(); chk("t1_wr_c1", wr_signal, 1); chk("t1_d_c1", o_wdata, 8'h05);
    adv(); smp(); chk("t1_wr_c2", wr_signal, 1); chk("t1_d_c2", o_wdata, 8'h03);
    adv(); smp(); chk("t1_wr_c3", wr_signal, 1); chk("t1_d_c3", o_wdata, 8'h20);
    adv(); smp(); chk("t1_rd_c4", rd_signal, 1); chk("t1_wr_c4", wr_signal, 0);
    adv(); rx_empty_signal = 1'b1; smp();
    chk("t1_done_c5", o_done_tick, 1); chk("t1_res_c5", o_result, 8'h08);
    adv(); smp(); chk("t1_busy_c6", o_busy, 0); chk("t1_done_c6", o_done_tick, 0);
    adv();

    // TX back-pressure on cycles 2..6
    start(8'hA1, 8'h3C, 6'h15);
    adv(); i_start = 1'b0; smp(); chk("t2_d_c1", o_wdata, 8'hA1);
    adv(); tx_full_signal = 1'b1; smp(); chk("t2_wr_c2", wr_signal, 0);
    adv(); adv(); adv(); adv();
    adv(); tx_full_signal = 1'b0; smp(); chk("t2_wr_c7", wr_signal, 1); chk("t2_d_c7", o_wdata, 8'h3C);
    adv(); smp(); chk("t2_wr_c8", wr_signal, 1); chk("t2_d_c8", o_wdata, 8'h15);
    adv(); rx_empty_signal = 1'b0; i_rdata = 8'h42; smp(); chk("t2_rd_c9", rd_signal, 1);
    adv(); rx_empty_signal = 1'b1; smp(); chk("t2_res_c10", o_result, 8'h42);
    adv(); adv();

    // Timeout: WAIT_RES occupies cycles 4..11, abort reported at 12
    start(8'h07, 8'h08, 6'h02);
    adv(); i_start = 1'b0;
    for (int c = 2; c <= 11; c++) adv();
    smp(); chk("t3_done_c11", o_done_tick, 0); chk("t3_busy_c11", o_busy, 1);
    adv(); smp();
    chk("t3_done_c12", o_done_tick, 1); chk("t3_to_c12", o_timeout, 1);
    chk("t3_res_c12", o_result, 8'h42); chk("t3_busy_c12", o_busy, 0);
    adv(); smp(); chk("t3_done_c13", o_done_tick, 0); chk("t3_to_c13", o_timeout, 1);
    adv();

    // Data arrives on the final timeout cycle
    start(8'h10, 8'h20, 6'h01);
    adv(); i_start = 1'b0; smp(); chk("t4_to_c1", o_timeout, 0);
    for (int c = 2; c <= 10; c++) adv();
    adv(); rx_empty_signal = 1'b0; i_rdata = 8'h99; smp(); chk("t4_rd_c11", rd_signal, 1);
    adv(); rx_empty_signal = 1'b1; smp();
    chk("t4_done_c12", o_done_tick, 1); chk("t4_to_c12", o_timeout, 0);
    chk("t4_res_c12", o_result, 8'h99);
    adv(); adv();

    // i_start while busy is ignored
    start(8'h01, 8'h02, 6'h03);
    adv(); i_start = 1'b0;
    adv(); start(8'hFF, 8'hEE, 6'h3F); smp(); chk("t5_d_c2", o_wdata, 8'h02);
    adv(); i_start = 1'b0; smp(); chk("t5_d_c3", o_wdata, 8'h03);
    adv(); rx_empty_signal = 1'b0; i_rdata = 8'h5A;
    adv(); rx_empty_signal = 1'b1; smp(); chk("t5_res", o_result, 8'h5A);
    adv(); adv();

    // Reset during SEND_B, then a clean restart
    start(8'h55, 8'h66, 6'h07);
    adv(); i_start = 1'b0;
    adv(); tx_full_signal = 1'b1; #3; reset = 1'b1; #1;
    chk("t6_rst_busy", o_busy, 0); chk("t6_rst_wdata", o_wdata, 0);
    chk("t6_rst_res", o_result, 0); chk("t6_rst_done", o_done_tick, 0);
    tx_full_signal = 1'b0; #1;
    chk("t6_rst_wr", wr_signal, 0);
    adv(); adv(); reset = 1'b0;
    adv(); smp(); chk("t6_idle_wr", wr_signal, 0);
    adv(); start(8'h12, 8'h34, 6'h01);
    adv(); i_start = 1'b0; smp(); chk("t6_d_c1", o_wdata, 8'h12);
    adv(); smp(); chk("t6_d_c2", o_wdata, 8'h34);
    adv(); smp(); chk("t6_d_c3", o_wdata, 8'h01);
    adv(); rx_empty_signal = 1'b0; i_rdata = 8'hC3;
    adv(); rx_empty_signal = 1'b1; smp(); chk("t6_res", o_result, 8'hC3);
    adv(); adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_alu_master.md
UART_ALU_MASTER -- requirements
Module: uart_alu_master

Interface
REQ-001 Parameter BUS_SIZE, 8, byte width of FIFO data and ALU operands.
REQ-002 Parameter TIMEOUT, 1000, max cycles spent in WAIT_RES before abort; legal range 2..2^20.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 i_start  in  1  request a transaction; sampled only in IDLE.
REQ-006 i_opA  in  BUS_SIZE  operand A.
REQ-007 i_opB  in  BUS_SIZE  operand B.
REQ-008 i_opCode  in  BUS_SIZE-2  ALU opcode.
REQ-009 tx_full_signal  in  1  TX FIFO full; no write is allowed while high.
REQ-010 wr_signal  out  1  TX FIFO write strobe, one byte per high cycle.
REQ-011 o_wdata  out  BUS_SIZE  byte presented to TX FIFO.
REQ-012 rx_empty_signal  in  1  RX FIFO empty.
REQ-013 i_rdata  in  BUS_SIZE  RX FIFO head byte; first-word-fall-through, valid whenever rx_empty_signal=0.
REQ-014 rd_signal  out  1  RX FIFO pop strobe.
REQ-015 o_result  out  BUS_SIZE  last received ALU result.
REQ-016 o_busy  out  1  high in every state except IDLE.
REQ-017 o_done_tick  out  1  one-cycle pulse at transaction end (success or timeout).
REQ-018 o_timeout  out  1  high when the last transaction aborted on timeout.

Function
REQ-019 FSM states: IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE.
REQ-020 IDLE with i_start=1: latch i_opA, i_opB, i_opCode into internal registers, clear o_timeout, go to SEND_A; i_start outside IDLE is ignored.
REQ-021 SEND_A/SEND_B/SEND_OP: o_wdata = latched A / B / {2'b00, opCode}; wr_signal = ~tx_full_signal (combinational); advance to the next state only on a cycle with wr_signal=1.
REQ-022 Byte order on the wire is fixed: A, B, OP; the byte is never duplicated or skipped while tx_full_signal stalls.
REQ-023 wr_signal is 0 in IDLE, WAIT_RES, and DONE; rd_signal is 0 in every state except WAIT_RES.
REQ-024 WAIT_RES: rd_signal = ~rx_empty_signal; on rd_signal=1, register i_rdata into o_result and go to DONE.
REQ-025 Timeout counter: cleared on entry to WAIT_RES, increments each WAIT_RES cycle with rx_empty_signal=1; at TIMEOUT-1 with FIFO still empty, go to IDLE, set o_timeout=1, pulse o_done_tick, and leave o_result unchanged.
REQ-026 If data arrives on the same cycle the counter reaches TIMEOUT-1, the data wins: pop it and go to DONE with no timeout.
REQ-027 DONE: o_done_tick=1 for exactly one cycle, then IDLE.
REQ-028 Latency with FIFOs never full or empty: i_start at cycle 0; wr_signal at cycles 1, 2, 3; rd_signal at 4; o_done_tick and new o_result at 5; o_busy falls at 6.
REQ-029 o_result and o_timeout hold their values until the next completion or start.

Reset
REQ-030 On reset assertion, immediately: state=IDLE, and all outputs (including o_result and o_timeout) plus the latched operands and timeout counter are 0.
REQ-031 Reset mid-transaction abandons it: no further wr_signal or rd_signal is issued, and partially sent bytes are not resent.

Verification
REQ-032 A=0x05, B=0x03, op=0x20, FIFOs free, RX delivers 0x08 at cycle 4 -> wr at cycles 1-3 with data 05, 03, 20; rd at 4; o_result=0x08; o_done_tick at 5.
REQ-033 tx_full_signal high for cycles 2-6 -> B is written once at cycle 7, OP at 8, and wr_signal is never high while full.
REQ-034 TIMEOUT=8, RX stays empty -> o_done_tick and o_timeout=1 after 8 WAIT_RES cycles; o_result keeps its previous value.
REQ-035 RX data arrives on the final timeout cycle -> result accepted, o_timeout=0.
REQ-036 i_start pulsed while busy -> ignored, and the operand registers are unchanged.
REQ-037 reset asserted during SEND_B -> outputs are 0 asynchronously; after release, a new i_start runs a clean A, B, OP sequence.
